misr_response_analyzer: RTL
===========================

# misr_response_analyzer

BIST response compactor and checker: the receiving end of the 9-bit pseudo-random pattern path (x^9 + x^4 + 1). It folds one circuit-under-test response word per cycle into a multiple-input signature register (MISR) built on the same polynomial and shift direction as the pattern generator. After a programmed number of responses it compares the signature against a golden value and reports pass/fail. It sits beside the CUT outputs and is started by the BIST controller together with the pattern generator.

## Interface
- `SEED`, 9'h000, signature value loaded on `start`.
- `NUM_PATTERNS`, 511, responses compacted per run; legal range 1..2^CNT_W-1.
- `CNT_W`, 16, width of the pattern counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a run; honoured in IDLE and DONE only.
- `resp_valid`  in  1  `resp` carries a response this cycle.
- `resp`  in  9  CUT response word.
- `golden`  in  9  expected signature; sampled when the final response is accepted.
- `resp_mask`  in  9  X-mask, 1 = bit forced to 0 before compaction; present only with `MISR_XMASK_EN`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  signature == golden; meaningful only while `done`=1.
- `signature`  out  9  current MISR contents.
- `count`  out  CNT_W  responses accepted in the current run.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with `signature`=0, `count`=0, `busy`=0, `done`=0, `pass`=0.
- IDLE --start--> RUN. On that edge `signature`<=SEED and `count`<=0.
- RUN, `resp_valid`=1: compaction, with r = resp (masked when enabled):
  - sig'[0] = sig[3] ^ sig[8] ^ r[0]
  - sig'[i] = sig[i-1] ^ r[i], for i = 1..8
  - `count` increments.
- RUN, `resp_valid`=0: signature and count hold. Gaps of any length are allowed.
- The final response is the one accepted when `count`==NUM_PATTERNS-1. On that edge the signature updates, `pass` <= (sig' == golden), and the state goes to DONE.
- DONE: `signature`, `count` and `pass` hold. DONE --start--> RUN, a restart with the same reload as from IDLE; `pass` clears to 0 on the restart edge.
- `start` in RUN is ignored. `resp_valid` in IDLE or DONE is ignored.
- `reset` has priority over everything. Reset mid-run aborts the run; no partial result is retained.
- NUM_PATTERNS=1: the first accepted response moves the block straight to DONE.

## Timing
- Compaction has one-cycle latency: `signature` reflects a response on the edge that accepts it.
- `busy` is high on the cycle after `start`.
- `done` and a valid `pass` appear on the cycle after the final response, together. `busy` drops on the same cycle.
- A run with no gaps takes NUM_PATTERNS+1 cycles from `start` to `done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MISR_XMASK_EN` defined:
  - the `resp_mask` port exists;
  - r = resp & ~resp_mask, applied combinationally before the MISR.
- Not defined:
  - no `resp_mask` port;
  - r = resp.
- State machine, timing and reset behaviour are identical in both builds.

## Test plan
- Single step: SEED=0, NUM_PATTERNS=1, start, then resp 9'h001 valid -> next cycle `signature`=9'h001, `done`=1, `count`=1; golden 9'h001 gives `pass`=1.
- Shift with pass/fail: NUM_PATTERNS=2, resp 9'h001 then 9'h000 -> `signature`=9'h002. Golden 9'h002 gives `pass`=1; rerun with golden 9'h003 gives `pass`=0.
- Feedback taps: SEED=9'h100, resp 0 for one beat -> 9'h001. SEED=9'h108, resp 0 -> 9'h010.
- Gaps and ignored inputs: `resp_valid` toggling 1,0,0,1 with `start` pulsed mid-run -> `count`=2, run not restarted. `resp_valid` asserted in IDLE -> signature unchanged.
- Reset mid-run: assert `reset` with `count`=5 -> next cycle IDLE, all outputs 0. A following `start` runs the full NUM_PATTERNS.
- Mask (with `MISR_XMASK_EN`): SEED=0, resp 9'h1FF, mask 9'h1FF -> `signature` stays 9'h000. Mask 9'h1FE -> `signature`=9'h001.

Source files
------------

// File: rtl/misr_response_analyzer_if.sv
// misr_response_analyzer_if
//   Bundles the response-analyser signals between the BIST controller / CUT
//   side (master) and the analyser itself (slave).
//   Optional macro: MISR_XMASK_EN adds the resp_mask X-mask signal.
//   master drives : start, resp_valid, resp, golden, [resp_mask]
//   slave drives  : busy, done, pass, signature, count
interface misr_response_analyzer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             resp_valid;
  logic [8:0]       resp;
  logic [8:0]       golden;
`ifdef MISR_XMASK_EN
  logic [8:0]       resp_mask;
`endif
  logic             busy;
  logic             done;
  logic             pass;
  logic [8:0]       signature;
  logic [CNT_W-1:0] count;

  modport master (
    output start, resp_valid, resp, golden,
`ifdef MISR_XMASK_EN
    output resp_mask,
`endif
    input  busy, done, pass, signature, count
  );

  modport slave (
    input  start, resp_valid, resp, golden,
`ifdef MISR_XMASK_EN
    input  resp_mask,
`endif
    output busy, done, pass, signature, count
  );
endinterface

// File: rtl/misr_response_analyzer.sv
// misr_response_analyzer
//   BIST response compactor. Folds one 9-bit CUT response per accepted beat
//   into a MISR on x^9 + x^4 + 1 (same shift direction as the pattern
//   generator), and after NUM_PATTERNS responses compares the signature with
//   the golden value.
//   Optional macro: MISR_XMASK_EN masks response bits (1 = forced to 0)
//   before compaction.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high reset
//   bus    slave side of misr_response_analyzer_if
//          (start, resp_valid, resp, golden, [resp_mask] in;
//           busy, done, pass, signature, count out, all registered)
module misr_response_analyzer #(
  parameter logic [8:0] SEED         = 9'h000,
  parameter int         NUM_PATTERNS = 511,
  parameter int         CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  misr_response_analyzer_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value at which the accepted response is the last one of the run.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  // One MISR clock: shift up, feedback from taps 3 and 8 into bit 0,
  // then fold the response word in.
  function automatic logic [8:0] misr_step(input logic [8:0] sig,
                                           input logic [8:0] r);
    misr_step = {sig[7:0], sig[3] ^ sig[8]} ^ r;
  endfunction

  state_t           state_r, state_s;
  logic [8:0]       sig_r, sig_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic             pass_r, pass_s;
  logic             busy_r;
  logic             done_r;
  logic [8:0]       resp_s;
  logic [8:0]       step_s;

  // Response word as seen by the MISR (X-masked when enabled).
  always_comb begin
`ifdef MISR_XMASK_EN
    resp_s = bus.resp & ~bus.resp_mask;
`else
    resp_s = bus.resp;
`endif
  end

  assign step_s = misr_step(sig_r, resp_s);

  // Next-state and next-value logic for the run controller.
  always_comb begin
    state_s = state_r;
    sig_s   = sig_r;
    count_s = count_r;
    pass_s  = pass_r;
    case (state_r)
      IDLE, DONE: begin
        // A (re)start reloads the seed; resp_valid is ignored here.
        if (bus.start) begin
          state_s = RUN;
          sig_s   = SEED;
          count_s = '0;
          pass_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        // start is ignored while running.
        if (bus.resp_valid) begin
          sig_s   = step_s;
          count_s = count_r + CNT_W'(1);
          if (count_r == LAST_CNT) begin
            state_s = DONE;
            pass_s  = (step_s == bus.golden);
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        sig_s   = 9'h000;
        count_s = '0;
        pass_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; busy/done are decoded from the next state so
  // they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sig_r   <= 9'h000;
      count_r <= '0;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sig_r   <= sig_s;
      count_r <= count_s;
      pass_r  <= pass_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.signature = sig_r;
  assign bus.count     = count_r;

endmodule
